// File: rtl/gtx_cfg_frame_rx_pkg.sv
// Shared constants, encodings and payload types for the GTX downlink
// configuration frame receiver and its helpers.
package gtx_cfg_frame_rx_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CTRL_W = 2;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned SUM_W  = 32;
    localparam int unsigned ERR_W  = 3;
    localparam int unsigned CNT_W  = 16;

    localparam logic [DATA_W-1:0] HDR0     = 16'h2410;
    localparam logic [DATA_W-1:0] HDR1     = 16'h1984;
    localparam logic [DATA_W-1:0] TRL0     = 16'hDBEF;
    localparam logic [DATA_W-1:0] TRL1     = 16'hE67B;
    localparam logic [DATA_W-1:0] CFG_TYPE = 16'h0001;
    localparam logic [DATA_W-1:0] CFG_LEN  = 16'h0018;

    // Word positions within the 32-word frame
    localparam logic [IDX_W-1:0] IDX_SEQ      = 5'd2;
    localparam logic [IDX_W-1:0] IDX_TYPE     = 5'd3;
    localparam logic [IDX_W-1:0] IDX_LEN      = 5'd4;
    localparam logic [IDX_W-1:0] IDX_SEC_HI   = 5'd6;
    localparam logic [IDX_W-1:0] IDX_SEC_LO   = 5'd7;
    localparam logic [IDX_W-1:0] IDX_USEC_HI  = 5'd8;
    localparam logic [IDX_W-1:0] IDX_USEC_LO  = 5'd9;
    localparam logic [IDX_W-1:0] IDX_STAR     = 5'd10;
    localparam logic [IDX_W-1:0] IDX_FREQ     = 5'd11;
    localparam logic [IDX_W-1:0] IDX_SPOT     = 5'd14;
    localparam logic [IDX_W-1:0] IDX_SUM_LAST = 5'd28;
    localparam logic [IDX_W-1:0] IDX_CSUM     = 5'd29;
    localparam logic [IDX_W-1:0] IDX_TRL1     = 5'd31;

    typedef enum logic [ERR_W-1:0] {
        ERR_NONE    = 3'd0,
        ERR_CSUM    = 3'd1,
        ERR_TRL     = 3'd2,
        ERR_TYPELEN = 3'd3,
        ERR_ABORT   = 3'd4
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_BODY   = 3'd2,
        ST_TRAIL  = 3'd3,
        ST_REPORT = 3'd4
    } state_e;

    typedef struct packed {
        logic [15:0] seq;
        logic [31:0] second;
        logic [31:0] usecond;
        logic [15:0] star;
        logic [15:0] freq;
        logic [15:0] spot;
    } cfg_fields_t;

endpackage

// File: rtl/gtx_cfg_frame_rx_if.sv
// RX word stream from the GTX link plus the decoded configuration / error
// reporting towards the command/control FSM.
interface gtx_cfg_frame_rx_if
    import gtx_cfg_frame_rx_pkg::*;
();
    logic [DATA_W-1:0] rx_data;
    logic [CTRL_W-1:0] rx_ctrl;
    logic              cfg_valid;
    logic [15:0]       cfg_seq_num;
    logic [31:0]       cfg_second;
    logic [31:0]       cfg_usecond;
    logic [15:0]       cfg_star_time;
    logic [15:0]       cfg_frequency;
    logic [15:0]       cfg_spot_time;
    logic              err_valid;
    logic [ERR_W-1:0]  err_code;
    logic [CNT_W-1:0]  good_cnt;
    logic [CNT_W-1:0]  err_cnt;

    modport master (
        output rx_data, rx_ctrl,
        input  cfg_valid, cfg_seq_num, cfg_second, cfg_usecond, cfg_star_time,
               cfg_frequency, cfg_spot_time, err_valid, err_code, good_cnt, err_cnt
    );

    modport slave (
        input  rx_data, rx_ctrl,
        output cfg_valid, cfg_seq_num, cfg_second, cfg_usecond, cfg_star_time,
               cfg_frequency, cfg_spot_time, err_valid, err_code, good_cnt, err_cnt
    );
endinterface

// File: rtl/gtx_cfg_frame_rx_csum.sv
// 32-bit wrapping word accumulator with clear/enable and a compare of its
// low 16 bits against a supplied checksum word.
module cfg_frame_csum
    import gtx_cfg_frame_rx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    input  logic [DATA_W-1:0] i_cmp,
    output logic              o_match_c
);
    logic [SUM_W-1:0] r_acc;

    // Clear wins over enable so a new frame always starts from zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + SUM_W'(i_data);
        end
    end

    assign o_match_c = (r_acc[DATA_W-1:0] == i_cmp);

endmodule

// File: rtl/gtx_cfg_frame_rx.sv
// Downlink configuration frame receiver: header hunt, 32-word capture,
// type/length/checksum/trailer validation and decoded-field presentation.
module gtx_cfg_frame_rx
    import gtx_cfg_frame_rx_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    gtx_cfg_frame_rx_if.slave  bus
);
    state_e            r_state;
    logic [IDX_W-1:0]  r_idx;
    cfg_fields_t       r_shadow;
    cfg_fields_t       r_cfg;
    logic              r_csum_fail;
    logic              r_trl_fail;
    logic              r_cfg_valid;
    logic              r_err_valid;
    err_code_e         r_err_code;
    logic [CNT_W-1:0]  r_good_cnt;
    logic [CNT_W-1:0]  r_err_cnt;

    logic              w_is_data;
    logic [DATA_W-1:0] w_word;
    logic              w_hdr0;
    logic              w_hdr1;
    logic              w_sum_clr;
    logic              w_sum_en;
    logic              w_csum_ok;
    logic              w_err_fire;
    err_code_e         w_err_code;
    logic              w_good_fire;

    assign w_is_data = (bus.rx_ctrl == 2'b00);
    assign w_word    = bus.rx_data;
    assign w_hdr0    = w_is_data && (w_word == HDR0);
    assign w_hdr1    = w_is_data && (w_word == HDR1);
    assign w_sum_clr = (r_state == ST_HDR) && w_hdr1;
    assign w_sum_en  = (r_state == ST_BODY) && w_is_data && (r_idx <= IDX_SUM_LAST);

    cfg_frame_csum u_csum (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_sum_clr),
        .i_en      (w_sum_en),
        .i_data    (w_word),
        .i_cmp     (w_word),
        .o_match_c (w_csum_ok)
    );

    // Frame verdict for the word on the bus this cycle; registered below
    always_comb begin
        w_err_fire  = 1'b0;
        w_err_code  = ERR_NONE;
        w_good_fire = 1'b0;
        case (r_state)
            ST_BODY: begin
                if (!w_is_data) begin
                    w_err_fire = 1'b1;
                    w_err_code = ERR_ABORT;
                end else if ((r_idx == IDX_TYPE && w_word != CFG_TYPE) ||
                             (r_idx == IDX_LEN  && w_word != CFG_LEN)) begin
                    w_err_fire = 1'b1;
                    w_err_code = ERR_TYPELEN;
                end
            end
            ST_TRAIL: begin
                if (!w_is_data) begin
                    w_err_fire = 1'b1;
                    w_err_code = ERR_ABORT;
                end else if (r_idx == IDX_TRL1) begin
                    if (r_csum_fail) begin
                        w_err_fire = 1'b1;
                        w_err_code = ERR_CSUM;
                    end else if (r_trl_fail || (w_word != TRL1)) begin
                        w_err_fire = 1'b1;
                        w_err_code = ERR_TRL;
                    end else begin
                        w_good_fire = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_shadow    <= '0;
            r_cfg       <= '0;
            r_csum_fail <= 1'b0;
            r_trl_fail  <= 1'b0;
            r_cfg_valid <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_good_cnt  <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_cfg_valid <= w_good_fire;
            r_err_valid <= w_err_fire;

            if (w_err_fire) begin
                r_err_code <= w_err_code;
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                end
            end

            if (w_good_fire) begin
                r_cfg      <= r_shadow;
                r_good_cnt <= r_good_cnt + CNT_W'(1);
            end

            case (r_state)
                // REPORT doubles as IDLE so a back-to-back header is not lost
                ST_IDLE, ST_REPORT: begin
                    r_state <= w_hdr0 ? ST_HDR : ST_IDLE;
                end
                ST_HDR: begin
                    if (w_hdr1) begin
                        r_state     <= ST_BODY;
                        r_idx       <= IDX_SEQ;
                        r_csum_fail <= 1'b0;
                        r_trl_fail  <= 1'b0;
                    end else if (w_hdr0) begin
                        r_state <= ST_HDR;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BODY: begin
                    if (w_err_fire) begin
                        r_state <= ST_IDLE;
                    end else begin
                        case (r_idx)
                            IDX_SEQ:     r_shadow.seq             <= w_word;
                            IDX_SEC_HI:  r_shadow.second[31:16]   <= w_word;
                            IDX_SEC_LO:  r_shadow.second[15:0]    <= w_word;
                            IDX_USEC_HI: r_shadow.usecond[31:16]  <= w_word;
                            IDX_USEC_LO: r_shadow.usecond[15:0]   <= w_word;
                            IDX_STAR:    r_shadow.star            <= w_word;
                            IDX_FREQ:    r_shadow.freq            <= w_word;
                            IDX_SPOT:    r_shadow.spot            <= w_word;
                            default: ;
                        endcase
                        if (r_idx == IDX_CSUM) begin
                            r_csum_fail <= !w_csum_ok;
                            r_state     <= ST_TRAIL;
                        end
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_TRAIL: begin
                    if (!w_is_data) begin
                        r_state <= ST_IDLE;
                    end else if (r_idx == IDX_TRL1) begin
                        r_state <= ST_REPORT;
                    end else begin
                        if (w_word != TRL0) begin
                            r_trl_fail <= 1'b1;
                        end
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cfg_valid     = r_cfg_valid;
    assign bus.cfg_seq_num   = r_cfg.seq;
    assign bus.cfg_second    = r_cfg.second;
    assign bus.cfg_usecond   = r_cfg.usecond;
    assign bus.cfg_star_time = r_cfg.star;
    assign bus.cfg_frequency = r_cfg.freq;
    assign bus.cfg_spot_time = r_cfg.spot;
    assign bus.err_valid     = r_err_valid;
    assign bus.err_code      = r_err_code;
    assign bus.good_cnt      = r_good_cnt;
    assign bus.err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_gtx_cfg_frame_rx.sv
// Scoreboard bench for gtx_cfg_frame_rx: frames are built in a word table,
// expected strobes are queued as words are driven and matched on output.
module tb_gtx_cfg_frame_rx;

    typedef struct {
        logic        good;
        logic [2:0]  code;
        int          cyc;
        logic [15:0] seq;
        logic [31:0] sec;
        logic [31:0] usec;
        logic [15:0] star;
        logic [15:0] freq;
        logic [15:0] spot;
        logic [15:0] gcnt;
        logic [15:0] ecnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    exp_t        q[$];
    logic [15:0] frm [32];

    logic [15:0] m_seq, m_star, m_freq, m_spot, m_good, m_err;
    logic [31:0] m_sec, m_usec;
    logic [2:0]  m_code;

    gtx_cfg_frame_rx_if bus ();

    gtx_cfg_frame_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: match each strobe against the oldest expectation
    task automatic sample();
        exp_t e;
        if (bus.cfg_valid || bus.err_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: cfg_valid=%0b err_valid=%0b at cycle %0d, required none",
                         bus.cfg_valid, bus.err_valid, cyc);
            end else begin
                e = q.pop_front();
                if ({bus.cfg_valid, bus.err_valid} !== {e.good, !e.good}) begin
                    errors++;
                    $display("FAIL strobe_kind: cfg/err=%0b%0b, required %0b%0b",
                             bus.cfg_valid, bus.err_valid, e.good, !e.good);
                end
                checks++;
                if (cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL latency: strobe at cycle %0d, required %0d", cyc, e.cyc);
                end
                checks++;
                if ({bus.cfg_seq_num, bus.cfg_second, bus.cfg_usecond, bus.cfg_star_time,
                     bus.cfg_frequency, bus.cfg_spot_time} !==
                    {e.seq, e.sec, e.usec, e.star, e.freq, e.spot}) begin
                    errors++;
                    $display("FAIL cfg_fields: seq=%h sec=%h usec=%h star=%h freq=%h spot=%h, required %h %h %h %h %h %h",
                             bus.cfg_seq_num, bus.cfg_second, bus.cfg_usecond, bus.cfg_star_time,
                             bus.cfg_frequency, bus.cfg_spot_time,
                             e.seq, e.sec, e.usec, e.star, e.freq, e.spot);
                end
                checks++;
                if ({bus.good_cnt, bus.err_cnt} !== {e.gcnt, e.ecnt}) begin
                    errors++;
                    $display("FAIL counters: good=%0d err=%0d, required good=%0d err=%0d",
                             bus.good_cnt, bus.err_cnt, e.gcnt, e.ecnt);
                end
                checks++;
                if (bus.err_code !== e.code) begin
                    errors++;
                    $display("FAIL err_code: %0d, required %0d", bus.err_code, e.code);
                end
            end
        end else if (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_strobe: none by cycle %0d, required one at cycle %0d", cyc, q[0].cyc);
            void'(q.pop_front());
        end
    endtask

    task automatic drive(input logic [15:0] w, input logic [1:0] c);
        @(negedge clk);
        sample();
        bus.rx_data = w;
        bus.rx_ctrl = c;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(16'h02bc, 2'b01);
    endtask

    task automatic push_exp(input logic good);
        exp_t e;
        e.good = good;
        e.code = m_code;
        e.cyc  = cyc + 1;
        e.seq  = m_seq;
        e.sec  = m_sec;
        e.usec = m_usec;
        e.star = m_star;
        e.freq = m_freq;
        e.spot = m_spot;
        e.gcnt = m_good;
        e.ecnt = m_err;
        q.push_back(e);
    endtask

    task automatic push_good();
        m_seq  = frm[2];
        m_sec  = {frm[6], frm[7]};
        m_usec = {frm[8], frm[9]};
        m_star = frm[10];
        m_freq = frm[11];
        m_spot = frm[14];
        m_good = m_good + 16'd1;
        push_exp(1'b1);
    endtask

    task automatic push_err(input logic [2:0] code);
        m_code = code;
        if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
        push_exp(1'b0);
    endtask

    task automatic reset_model();
        m_seq = '0; m_sec = '0; m_usec = '0; m_star = '0; m_freq = '0; m_spot = '0;
        m_good = '0; m_err = '0; m_code = '0;
    endtask

    task automatic make_frame(input logic [15:0] seq, input logic [31:0] sec, input logic [31:0] usec,
                              input logic [15:0] star, input logic [15:0] freq, input logic [15:0] spot);
        logic [31:0] s;
        for (int i = 0; i < 32; i++) frm[i] = '0;
        frm[0] = 16'h2410; frm[1] = 16'h1984;
        frm[2] = seq; frm[3] = 16'h0001; frm[4] = 16'h0018; frm[5] = 16'h0021;
        frm[6] = sec[31:16]; frm[7] = sec[15:0];
        frm[8] = usec[31:16]; frm[9] = usec[15:0];
        frm[10] = star; frm[11] = freq; frm[14] = spot;
        s = '0;
        for (int i = 2; i <= 28; i++) s = s + 32'(frm[i]);
        frm[29] = s[15:0];
        frm[30] = 16'hDBEF; frm[31] = 16'hE67B;
    endtask

    // Drives frm[] and queues the outcome the bench's own frame model predicts
    task automatic send_frame(input int abort_at);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < 32; i++) begin
            if (i == abort_at) begin
                drive(16'h02bc, 2'b01);
                push_err(3'd4);
                return;
            end
            drive(frm[i], 2'b00);
            if (i >= 2 && i <= 28) s = s + 32'(frm[i]);
            if ((i == 3 && frm[3] != 16'h0001) || (i == 4 && frm[4] != 16'h0018)) begin
                push_err(3'd3);
                return;
            end
            if (i == 31) begin
                if (frm[29] != s[15:0])                                push_err(3'd1);
                else if (frm[30] != 16'hDBEF || frm[31] != 16'hE67B)   push_err(3'd2);
                else                                                   push_good();
            end
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: %0d strobes outstanding, required 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks++;
        if ({bus.cfg_valid, bus.err_valid, bus.err_code, bus.good_cnt, bus.err_cnt,
             bus.cfg_seq_num, bus.cfg_second, bus.cfg_usecond, bus.cfg_star_time,
             bus.cfg_frequency, bus.cfg_spot_time} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: nonzero output after reset (good=%0d err=%0d code=%0d), required all 0",
                     bus.good_cnt, bus.err_cnt, bus.err_code);
        end
        rst = 1'b0;
    endtask

    task automatic test_good();
        idle(4);
        make_frame(16'd0, 32'h10, 32'h12, 16'h10, 16'h1, 16'h18);
        send_frame(-1);
        idle(3);
        checks++;
        if (bus.cfg_second !== 32'h10 || bus.cfg_usecond !== 32'h12 || bus.cfg_spot_time !== 16'h18) begin
            errors++;
            $display("FAIL good_fields: sec=%h usec=%h spot=%h, required 10 12 18",
                     bus.cfg_second, bus.cfg_usecond, bus.cfg_spot_time);
        end
        checks++;
        if (bus.good_cnt !== 16'd1) begin
            errors++;
            $display("FAIL good_cnt: %0d, required 1", bus.good_cnt);
        end
        check_drained("good");
    endtask

    task automatic test_checksum();
        make_frame(16'd0, 32'h10, 32'h12, 16'h10, 16'h1, 16'h18);
        frm[29] = 16'h0086;
        send_frame(-1);
        idle(3);
        checks++;
        if (bus.err_code !== 3'd1 || bus.err_cnt !== 16'd1 || bus.cfg_second !== 32'h10) begin
            errors++;
            $display("FAIL checksum_err: code=%0d err_cnt=%0d sec=%h, required 1 1 10",
                     bus.err_code, bus.err_cnt, bus.cfg_second);
        end
        check_drained("checksum");
    endtask

    task automatic test_trailer_typelen();
        make_frame(16'h55, 32'h77, 32'h99, 16'h3, 16'h4, 16'h5);
        frm[31] = 16'hE67A;
        send_frame(-1);
        idle(2);
        checks++;
        if (bus.err_code !== 3'd2) begin
            errors++;
            $display("FAIL trailer_err: code=%0d, required 2", bus.err_code);
        end
        make_frame(16'h56, 32'h77, 32'h99, 16'h3, 16'h4, 16'h5);
        frm[4] = 16'h0019;
        send_frame(-1);
        idle(3);
        checks++;
        if (bus.err_code !== 3'd3 || bus.cfg_seq_num !== 16'd0) begin
            errors++;
            $display("FAIL typelen_err: code=%0d seq=%h, required 3 0000", bus.err_code, bus.cfg_seq_num);
        end
        check_drained("trailer_typelen");
    endtask

    task automatic test_abort();
        make_frame(16'd7, 32'hAAAA_0001, 32'hBBBB_0002, 16'h11, 16'h22, 16'h33);
        send_frame(15);
        idle(2);
        checks++;
        if (bus.err_code !== 3'd4 || bus.err_cnt !== 16'd4) begin
            errors++;
            $display("FAIL abort_err: code=%0d err_cnt=%0d, required 4 4", bus.err_code, bus.err_cnt);
        end
        make_frame(16'd8, 32'hFFFF_FFFF, 32'h0001_0000, 16'hFFFE, 16'h1234, 16'hABCD);
        send_frame(-1);
        idle(3);
        checks++;
        if (bus.cfg_seq_num !== 16'd8 || bus.good_cnt !== 16'd2 || bus.cfg_spot_time !== 16'hABCD) begin
            errors++;
            $display("FAIL after_abort: seq=%0d good=%0d spot=%h, required 8 2 abcd",
                     bus.cfg_seq_num, bus.good_cnt, bus.cfg_spot_time);
        end
        check_drained("abort");
    endtask

    task automatic test_back_to_back();
        make_frame(16'd1, 32'h100, 32'h200, 16'h1, 16'h2, 16'h3);
        send_frame(-1);
        make_frame(16'd2, 32'h101, 32'h201, 16'h4, 16'h5, 16'h6);
        send_frame(-1);
        idle(3);
        checks++;
        if (bus.cfg_seq_num !== 16'd2 || bus.good_cnt !== 16'd4) begin
            errors++;
            $display("FAIL back_to_back: seq=%0d good=%0d, required 2 4", bus.cfg_seq_num, bus.good_cnt);
        end
        check_drained("back_to_back");
    endtask

    task automatic test_rst_midframe();
        make_frame(16'd3, 32'h300, 32'h400, 16'h7, 16'h8, 16'h9);
        drive(16'h2410, 2'b00);
        send_frame(-1);
        idle(2);
        checks++;
        if (bus.cfg_seq_num !== 16'd3) begin
            errors++;
            $display("FAIL double_hdr: seq=%0d, required 3", bus.cfg_seq_num);
        end
        check_drained("double_hdr");
        make_frame(16'd4, 32'h500, 32'h600, 16'hA, 16'hB, 16'hC);
        for (int i = 0; i < 20; i++) drive(frm[i], 2'b00);
        @(negedge clk);
        sample();
        rst = 1'b1;
        bus.rx_data = frm[20];
        bus.rx_ctrl = 2'b00;
        for (int i = 21; i < 24; i++) drive(frm[i], 2'b00);
        rst = 1'b0;
        reset_model();
        for (int i = 24; i < 32; i++) drive(frm[i], 2'b00);
        idle(4);
        checks++;
        if (bus.good_cnt !== 16'd0 || bus.err_cnt !== 16'd0 || bus.cfg_seq_num !== 16'd0) begin
            errors++;
            $display("FAIL rst_midframe: good=%0d err=%0d seq=%0d, required 0 0 0",
                     bus.good_cnt, bus.err_cnt, bus.cfg_seq_num);
        end
        check_drained("rst_midframe");
    endtask

    initial begin
        bus.rx_data = 16'h02bc;
        bus.rx_ctrl = 2'b01;
        reset_model();
        test_reset();
        test_good();
        test_checksum();
        test_trailer_typelen();
        test_abort();
        test_back_to_back();
        test_rst_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
